// File: rtl/flow_led_ctrl.sv
// Parametrised LED pattern engine: prescaled step strobe driving rotate-left,
// rotate-right, bounce and fill/drain patterns across LED_NUM outputs.
module flow_led_ctrl #(
    parameter int LED_NUM = 4,
    parameter int CNT_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   period,
    output logic [LED_NUM-1:0] led,
    output logic               step
);

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    localparam logic [LED_NUM-1:0] LED_SEED = LED_NUM'(1);

    mode_e              mode_q, mode_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               step_q, step_d;

    logic               tick;
    logic [LED_NUM-1:0] shiftUp;
    logic [LED_NUM-1:0] shiftDown;
    logic [LED_NUM-1:0] rotUp;
    logic [LED_NUM-1:0] rotDown;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_ROTL;
            led_q  <= LED_SEED;
            dir_q  <= 1'b0;
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign tick      = en && (cnt_q >= period);
    assign shiftUp   = led_q << 1;
    assign shiftDown = led_q >> 1;
    assign rotUp     = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
    assign rotDown   = {led_q[0], led_q[LED_NUM-1:1]};

    // A mode change reseeds everything and wins over a coincident tick, even with en low.
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        dir_d  = dir_q;
        cnt_d  = cnt_q;
        step_d = 1'b0;

        if (mode != mode_q) begin
            mode_d = mode_e'(mode);
            led_d  = LED_SEED;
            dir_d  = 1'b0;
            cnt_d  = '0;
        end else if (tick) begin
            cnt_d  = '0;
            step_d = 1'b1;
            case (mode_q)
                MODE_ROTL: led_d = rotUp;
                MODE_ROTR: led_d = rotDown;
                MODE_BOUNCE: begin
                    if (!dir_q && led_q[LED_NUM-1]) begin
                        dir_d = 1'b1;
                        led_d = shiftDown;
                    end else if (dir_q && led_q[0]) begin
                        dir_d = 1'b0;
                        led_d = shiftUp;
                    end else begin
                        led_d = dir_q ? shiftDown : shiftUp;
                    end
                end
                MODE_FILL: begin
                    if (!dir_q && (&led_q)) begin
                        dir_d = 1'b1;
                        led_d = shiftUp;
                    end else if (!dir_q) begin
                        led_d = shiftUp | LED_SEED;
                    end else if (led_q == '0) begin
                        dir_d = 1'b0;
                        led_d = LED_SEED;
                    end else begin
                        led_d = shiftUp;
                    end
                end
                default: led_d = led_q;
            endcase
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Directed checks for flow_led_ctrl: a vector table for the pattern sequences
// plus hand-written sequences for enable gating, period change, reseed and reset.
module tb_flow_led_ctrl;

    localparam int LED_NUM = 4;
    localparam int CNT_W   = 24;

    logic               clk;
    logic               rst;
    logic               en;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   period;
    logic [LED_NUM-1:0] led;
    logic               step;

    int total;
    int bad;

    typedef struct {
        logic               vecEn;
        logic [1:0]         vecMode;
        logic [CNT_W-1:0]   vecPeriod;
        logic [LED_NUM-1:0] expLed;
        logic               expStep;
    } vec_t;

    vec_t vecs[$];

    flow_led_ctrl #(
        .LED_NUM(LED_NUM),
        .CNT_W  (CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .period(period),
        .led   (led),
        .step  (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [CNT_W-1:0] p);
        en     = e;
        mode   = m;
        period = p;
    endtask

    task automatic checkOutput(input string name, input logic [LED_NUM-1:0] expLed, input logic expStep);
        total++;
        if (led !== expLed || step !== expStep) begin
            bad++;
            $display("[TB] FAIL %s: got led=%b step=%b, want led=%b step=%b",
                     name, led, step, expLed, expStep);
        end
    endtask

    task automatic tickCheck(input string name, input logic [LED_NUM-1:0] expLed, input logic expStep);
        @(posedge clk);
        #1;
        checkOutput(name, expLed, expStep);
    endtask

    function automatic void addVec(input logic e, input logic [1:0] m, input logic [CNT_W-1:0] p,
                                   input logic [LED_NUM-1:0] l, input logic s);
        vec_t v;
        v.vecEn     = e;
        v.vecMode   = m;
        v.vecPeriod = p;
        v.expLed    = l;
        v.expStep   = s;
        vecs.push_back(v);
    endfunction

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Rotate left, period 2: each value held three edges.
        addVec(1, 0, 2, 4'b0001, 0);
        addVec(1, 0, 2, 4'b0001, 0);
        addVec(1, 0, 2, 4'b0010, 1);
        addVec(1, 0, 2, 4'b0010, 0);
        addVec(1, 0, 2, 4'b0010, 0);
        addVec(1, 0, 2, 4'b0100, 1);
        addVec(1, 0, 2, 4'b0100, 0);
        addVec(1, 0, 2, 4'b0100, 0);
        addVec(1, 0, 2, 4'b1000, 1);
        addVec(1, 0, 2, 4'b1000, 0);
        addVec(1, 0, 2, 4'b1000, 0);
        addVec(1, 0, 2, 4'b0001, 1);
        // Bounce, period 0: reseed edge then an advance every edge.
        addVec(1, 2, 0, 4'b0001, 0);
        addVec(1, 2, 0, 4'b0010, 1);
        addVec(1, 2, 0, 4'b0100, 1);
        addVec(1, 2, 0, 4'b1000, 1);
        addVec(1, 2, 0, 4'b0100, 1);
        addVec(1, 2, 0, 4'b0010, 1);
        addVec(1, 2, 0, 4'b0001, 1);
        addVec(1, 2, 0, 4'b0010, 1);
        // Fill/drain, period 0.
        addVec(1, 3, 0, 4'b0001, 0);
        addVec(1, 3, 0, 4'b0011, 1);
        addVec(1, 3, 0, 4'b0111, 1);
        addVec(1, 3, 0, 4'b1111, 1);
        addVec(1, 3, 0, 4'b1110, 1);
        addVec(1, 3, 0, 4'b1100, 1);
        addVec(1, 3, 0, 4'b1000, 1);
        addVec(1, 3, 0, 4'b0000, 1);
        addVec(1, 3, 0, 4'b0001, 1);
        // Reseed with en low still reloads the seed.
        addVec(0, 1, 0, 4'b0001, 0);
        addVec(0, 1, 0, 4'b0001, 0);

        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, '0);
        #1;
        checkOutput("resetAsync", 4'b0001, 1'b0);
        doReset();
        checkOutput("resetHold", 4'b0001, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].vecEn, vecs[i].vecMode, vecs[i].vecPeriod);
            tickCheck($sformatf("vec%0d", i), vecs[i].expLed, vecs[i].expStep);
        end

        // Enable gating: freeze at cnt=3 for ten cycles, then three more enabled edges.
        doReset();
        applyStimulus(1'b1, 2'd0, 24'd5);
        for (int i = 0; i < 3; i++) tickCheck($sformatf("gateRun%0d", i), 4'b0001, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) tickCheck($sformatf("gateHold%0d", i), 4'b0001, 1'b0);
        en = 1'b1;
        tickCheck("gateResume0", 4'b0001, 1'b0);
        tickCheck("gateResume1", 4'b0001, 1'b0);
        tickCheck("gateAdvance", 4'b0010, 1'b1);

        // Lowering period below the current count wraps on the next edge.
        for (int i = 0; i < 4; i++) tickCheck($sformatf("perRun%0d", i), 4'b0010, 1'b0);
        period = 24'd1;
        tickCheck("perWrap", 4'b0100, 1'b1);
        tickCheck("perShort0", 4'b0100, 1'b0);
        tickCheck("perShort1", 4'b1000, 1'b1);

        // Mode switch on the tick edge: bounce at 0100 heading down, switch to rotate right.
        doReset();
        applyStimulus(1'b1, 2'd2, 24'd0);
        tickCheck("swSeed", 4'b0001, 1'b0);
        tickCheck("swB1", 4'b0010, 1'b1);
        tickCheck("swB2", 4'b0100, 1'b1);
        tickCheck("swB3", 4'b1000, 1'b1);
        tickCheck("swB4", 4'b0100, 1'b1);
        period = 24'd2;
        tickCheck("swWait0", 4'b0100, 1'b0);
        tickCheck("swWait1", 4'b0100, 1'b0);
        mode = 2'd1;
        tickCheck("swReseed", 4'b0001, 1'b0);
        tickCheck("swR0", 4'b0001, 1'b0);
        tickCheck("swR1", 4'b0001, 1'b0);
        tickCheck("swAdvance", 4'b1000, 1'b1);

        // Asynchronous reset between edges while showing 1000 with step high.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstImmediate", 4'b0001, 1'b0);
        tickCheck("rstHold0", 4'b0001, 1'b0);
        tickCheck("rstHold1", 4'b0001, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 2'd0, 24'd0);
        tickCheck("rstRestart", 4'b0010, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
